lbp_img_host: RTL and testbench

- Image-side responder for the LBP engine's gray/lbp memory interface.
- Owns a 128x128 8-bit gray image memory, loaded from a byte stream. Serves zero-latency reads to the engine and raises `gray_ready` once the image is loaded.
- Captures every LBP result write into a result memory. Tracks write coverage and protocol errors, and closes the run on `finish`.
- Sits between the testbench/host loader and the LBP engine; results are read back through a registered port.

---
 rtl/lbp_img_host.sv | 150 +++++++++++++++
 tb/tb_lbp_img_host.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_img_host.sv
// Image-side responder for the LBP engine: gray image store with zero-latency reads,
// result capture with write-coverage tracking, and run close/restart control.
module lbp_img_host #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                restart,
    output logic                gray_ready,
    input  logic [ADDR_W-1:0]   gray_addr,
    input  logic                gray_req,
    output logic [DATA_W-1:0]   gray_data,
    input  logic [ADDR_W-1:0]   lbp_addr,
    input  logic                lbp_valid,
    input  logic [DATA_W-1:0]   lbp_data,
    input  logic                finish,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                done,
    output logic                complete,
    output logic [ADDR_W:0]     wr_count,
    output logic [ADDR_W+5:0]   req_count,
    output logic [1:0]          err
);
    localparam int NPIX = 1 << ADDR_W;
    localparam logic [ADDR_W:0] WR_FULL = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [DATA_W-1:0] img_mem [NPIX];
    logic [DATA_W-1:0] res_mem [NPIX];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic [NPIX-1:0]   bitmap_q, bitmap_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic [ADDR_W+5:0] req_count_q, req_count_d;
    logic [1:0]        err_q, err_d;
    logic              gray_ready_q, gray_ready_d;
    logic              done_q, done_d;
    logic              complete_q, complete_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              img_we, res_we;

    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        bitmap_d    = bitmap_q;
        wr_count_d  = wr_count_q;
        req_count_d = req_count_q;
        err_d       = err_q;
        complete_d  = complete_q;
        img_we      = 1'b0;
        res_we      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    img_we     = 1'b1;
                    load_ptr_d = load_ptr_q + 1'b1;
                    if (load_ptr_q == {ADDR_W{1'b1}})
                        state_d = ST_SERVE;
                end
                if (lbp_valid || gray_req)
                    err_d[1] = 1'b1;
            end
            ST_SERVE: begin
                if (lbp_valid) begin
                    res_we = 1'b1;
                    if (bitmap_q[lbp_addr])
                        err_d[0] = 1'b1;
                    bitmap_d[lbp_addr] = 1'b1;
                    if (wr_count_q != WR_FULL)
                        wr_count_d = wr_count_q + 1'b1;
                end
                if (gray_req && req_count_q != {(ADDR_W+6){1'b1}})
                    req_count_d = req_count_q + 1'b1;
                // A write landing alongside finish is included in the verdict.
                if (finish) begin
                    state_d    = ST_DONE;
                    complete_d = (wr_count_d == WR_FULL) && !err_d[0];
                end
            end
            ST_DONE: begin
                if (lbp_valid || gray_req)
                    err_d[1] = 1'b1;
                if (restart) begin
                    state_d     = ST_LOAD;
                    load_ptr_d  = '0;
                    bitmap_d    = '0;
                    wr_count_d  = '0;
                    req_count_d = '0;
                    err_d       = '0;
                    complete_d  = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        gray_ready_d = (state_d == ST_SERVE);
        done_d       = (state_d == ST_DONE);
        rd_data_d    = res_mem[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            load_ptr_q   <= '0;
            bitmap_q     <= '0;
            wr_count_q   <= '0;
            req_count_q  <= '0;
            err_q        <= '0;
            gray_ready_q <= 1'b0;
            done_q       <= 1'b0;
            complete_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            bitmap_q     <= bitmap_d;
            wr_count_q   <= wr_count_d;
            req_count_q  <= req_count_d;
            err_q        <= err_d;
            gray_ready_q <= gray_ready_d;
            done_q       <= done_d;
            complete_q   <= complete_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Memories are deliberately left out of reset; contents survive restart.
    always_ff @(posedge clk) begin
        if (img_we)
            img_mem[load_ptr_q] <= load_data;
        if (res_we)
            res_mem[lbp_addr] <= lbp_data;
    end

    assign gray_data  = img_mem[gray_addr];
    assign gray_ready = gray_ready_q;
    assign rd_data    = rd_data_q;
    assign done       = done_q;
    assign complete   = complete_q;
    assign wr_count   = wr_count_q;
    assign req_count  = req_count_q;
    assign err        = err_q;
endmodule

// File: tb/tb_lbp_img_host.sv
// Bench for lbp_img_host: constant vector tables plus randomized runs checked
// against a pixel-level model (per-address hit counts, image/result arrays).
module tb_lbp_img_host;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int NPIX = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          restart;
    logic          gray_ready;
    logic [AW-1:0] gray_addr;
    logic          gray_req;
    logic [DW-1:0] gray_data;
    logic [AW-1:0] lbp_addr;
    logic          lbp_valid;
    logic [DW-1:0] lbp_data;
    logic          finish;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          complete;
    logic [AW:0]   wr_count;
    logic [AW+5:0] req_count;
    logic [1:0]    err;

    lbp_img_host #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .restart(restart), .gray_ready(gray_ready), .gray_addr(gray_addr),
        .gray_req(gray_req), .gray_data(gray_data), .lbp_addr(lbp_addr),
        .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish),
        .rd_addr(rd_addr), .rd_data(rd_data), .done(done), .complete(complete),
        .wr_count(wr_count), .req_count(req_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t gvec[5];
    vec_t rvec[5];

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] img_m [NPIX];
    logic [DW-1:0] res_m [NPIX];
    int hits [NPIX];
    int n_wr;
    int n_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_run();
        for (int i = 0; i < NPIX; i++) hits[i] = 0;
        n_wr = 0;
        n_req = 0;
    endtask

    function automatic logic exp_dup();
        for (int i = 0; i < NPIX; i++) if (hits[i] > 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_complete();
        for (int i = 0; i < NPIX; i++) if (hits[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_image(input bit gaps, input bit rnd);
        logic [DW-1:0] d;
        for (int i = 0; i < NPIX; i++) begin
            if (gaps && $urandom_range(7) == 0) begin
                load_valid = 1'b0;
                step();
            end
            d = rnd ? DW'($urandom) : DW'(i);
            load_valid = 1'b1;
            load_data = d;
            img_m[i] = d;
            if (i == NPIX - 1) chk("ready_before_last_byte", {31'b0, gray_ready}, 32'd0);
            step();
        end
        load_valid = 1'b0;
        chk("ready_after_load", {31'b0, gray_ready}, 32'd1);
    endtask

    task automatic write_px(input int a, input logic [DW-1:0] d, input bit fin);
        lbp_valid = 1'b1;
        lbp_addr = AW'(a);
        lbp_data = d;
        finish = fin;
        gray_req = 1'($urandom_range(1));
        gray_addr = AW'($urandom);
        #1;
        if ((a % 1024) == 0) chk("gray_data_serve", {24'b0, gray_data}, {24'b0, img_m[gray_addr]});
        res_m[a] = d;
        hits[a]++;
        n_wr++;
        if (gray_req) n_req++;
        step();
        lbp_valid = 1'b0;
        finish = 1'b0;
        gray_req = 1'b0;
    endtask

    task automatic check_run_end(input string tag);
        int ew;
        ew = (n_wr > NPIX) ? NPIX : n_wr;
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_ready_low"}, {31'b0, gray_ready}, 32'd0);
        chk({tag, "_complete"}, {31'b0, complete}, {31'b0, exp_complete()});
        chk({tag, "_wr_count"}, {17'b0, wr_count}, ew);
        chk({tag, "_err"}, {30'b0, err}, {31'b0, exp_dup()});
        chk({tag, "_req_count"}, {12'b0, req_count}, n_req);
    endtask

    task automatic rd(input int a, input logic [DW-1:0] exp, input string name);
        rd_addr = AW'(a);
        step();
        chk(name, {24'b0, rd_data}, {24'b0, exp});
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        #2;
        chk("reset_ready", {31'b0, gray_ready}, 32'd0);
        chk("reset_err", {30'b0, err}, 32'd0);
        reset = 1'b0;
        step();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        gvec[0] = '{14'h0181, 8'h81};
        gvec[1] = '{14'h0000, 8'h00};
        gvec[2] = '{14'h3fff, 8'hff};
        gvec[3] = '{14'h1234, 8'h34};
        gvec[4] = '{14'h00fe, 8'hfe};
        rvec[0] = '{14'h0203, 8'h03};
        rvec[1] = '{14'h0000, 8'h00};
        rvec[2] = '{14'h3fff, 8'hff};
        rvec[3] = '{14'h01ab, 8'hab};
        rvec[4] = '{14'h2a5c, 8'h5c};

        reset = 1'b1;
        load_valid = 0; load_data = 0; restart = 0; gray_addr = 0; gray_req = 0;
        lbp_addr = 0; lbp_valid = 0; lbp_data = 0; finish = 0; rd_addr = 0;
        step();
        step();
        chk("rst_gray_ready", {31'b0, gray_ready}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_complete", {31'b0, complete}, 32'd0);
        chk("rst_wr_count", {17'b0, wr_count}, 32'd0);
        chk("rst_req_count", {12'b0, req_count}, 32'd0);
        chk("rst_err", {30'b0, err}, 32'd0);
        chk("rst_rd_data", {24'b0, rd_data}, 32'd0);
        reset = 1'b0;
        step();

        // Partial load aborted by reset at byte 100; full reload must start from 0.
        for (int i = 0; i < 100; i++) begin
            load_valid = 1'b1;
            load_data = 8'hc3;
            step();
        end
        load_valid = 1'b0;
        reset_pulse();
        load_image(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            gray_addr = gvec[i].addr;
            #1;
            chk("gray_vec", {24'b0, gray_data}, {24'b0, gvec[i].exp});
        end

        // Run A: ordered writes, last one coincides with finish.
        model_clear_run();
        for (int a = 0; a < NPIX; a++) write_px(a, DW'(a), a == NPIX - 1);
        check_run_end("runA");
        for (int i = 0; i < 5; i++) rd(rvec[i].addr, rvec[i].exp, "rd_vec");
        for (int i = 0; i < 10; i++) begin
            int a;
            a = $urandom_range(NPIX - 1);
            rd(a, res_m[a], "rd_rand_A");
        end

        // DONE holds: late finish and load bytes change nothing.
        load_valid = 1'b1;
        finish = 1'b1;
        step();
        load_valid = 1'b0;
        finish = 1'b0;
        chk("done_hold", {31'b0, done}, 32'd1);
        chk("done_hold_wr", {17'b0, wr_count}, NPIX);

        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_done", {31'b0, done}, 32'd0);
        chk("restart_ready", {31'b0, gray_ready}, 32'd0);
        chk("restart_wr", {17'b0, wr_count}, 32'd0);
        chk("restart_err", {30'b0, err}, 32'd0);
        chk("restart_complete", {31'b0, complete}, 32'd0);
        chk("restart_req", {12'b0, req_count}, 32'd0);

        // Engine activity during LOAD: flagged, not written, not counted.
        lbp_valid = 1'b1; lbp_addr = 14'h0010; lbp_data = 8'hee; gray_req = 1'b1;
        step();
        lbp_valid = 1'b0; gray_req = 1'b0;
        chk("oos_err", {30'b0, err}, 32'd2);
        chk("oos_wr", {17'b0, wr_count}, 32'd0);
        chk("oos_req", {12'b0, req_count}, 32'd0);
        rd(14'h0010, res_m[16], "oos_result_kept");

        reset_pulse();
        load_image(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            gray_addr = AW'($urandom);
            #1;
            chk("gray_rand", {24'b0, gray_data}, {24'b0, img_m[gray_addr]});
        end

        // Run B: address 5 twice, address 6 skipped, separate finish.
        model_clear_run();
        for (int a = 0; a < NPIX; a++) begin
            if (a == 6) continue;
            if (a == 5) begin
                write_px(5, 8'haa, 1'b0);
                write_px(5, 8'h55, 1'b0);
            end else begin
                write_px(a, DW'($urandom), 1'b0);
            end
        end
        finish = 1'b1;
        step();
        finish = 1'b0;
        check_run_end("runB");
        chk("runB_err_exact", {30'b0, err}, 32'd1);
        chk("runB_complete_exact", {31'b0, complete}, 32'd0);
        rd(5, 8'h55, "rd_last_wins");
        rd(6, 8'h06, "rd_skipped_kept");
        for (int i = 0; i < 10; i++) begin
            int a;
            a = $urandom_range(NPIX - 1);
            rd(a, res_m[a], "rd_rand_B");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
